// File: rtl/pk_byte_loader.sv
// pk_byte_loader: byte-serial ingress for the ML-DSA public key.
// Collects PK_BYTES bytes over a valid/ready handshake, little-endian, into
// a flat register and presents it with a held out_valid until out_ack.
// Optional feature macro: PK_LOADER_ERR_EN (sticky protocol-error flag).
module pk_byte_loader #(
   parameter  int K             = 8,
   parameter  int T1_POLY_BYTES = 320,
   localparam int PK_BYTES      = 32 + K * T1_POLY_BYTES,
   localparam int CNT_W         = $clog2(PK_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [8*PK_BYTES-1:0] pk_out,
   output logic                  out_valid,
   input  logic                  out_ack,
   output logic                  busy,
   output logic [CNT_W-1:0]      byte_cnt,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   cnt_clr;
   logic   wr_en;
   logic   last_byte;

   // A restart in LOAD wins over a byte presented in the same cycle.
   assign wr_en     = in_valid & in_ready & ~start;
   assign last_byte = (byte_cnt == CNT_W'(PK_BYTES - 1));

   // Handshake flags decode from the state register only.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DONE);
   assign busy      = (state == LOAD) || (state == DONE);

   // Next-state and counter-clear decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_nxt = state;
      cnt_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               cnt_clr   = 1'b1;
            end
         end
         LOAD: begin
            if (start) begin
               cnt_clr = 1'b1;
            end else if (wr_en && last_byte) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ack) begin
               if (start) begin
                  state_nxt = LOAD;
                  cnt_clr   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Byte counter: cleared on (re)start, advanced on each accepted byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
      end else if (cnt_clr) begin
         byte_cnt <= '0;
      end else if (wr_en) begin
         byte_cnt <= byte_cnt + CNT_W'(1);
      end
   end

   // Key register: accepted byte lands in slot byte_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: this wide register is reset on purpose: its all-zero reset value is visible on pk_out, and a reset must discard any partial key.
      if (!rst_n) begin
         pk_out <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < PK_BYTES; i++) begin
            if (byte_cnt == CNT_W'(i)) begin
               pk_out[8*i +: 8] <= in_data;
            end
         end
      end
   end

`ifdef PK_LOADER_ERR_EN
   logic err_q;

   // Sticky error: bytes offered outside LOAD, or start in DONE without ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if ((in_valid && ((state == IDLE) || (state == DONE))) ||
                   ((state == DONE) && start && !out_ack)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/pk_byte_loader.md
# pk_byte_loader

Byte-stream ingress stage that sits directly upstream of the public-key decoder. It accepts the encoded ML-DSA public key one byte per cycle over a valid/ready handshake and assembles it little-endian into a flat register: byte 0 lands in bits [7:0], so rho occupies bits [255:0] and the packed t1 polynomials follow. When the full key is present it raises a held `out_valid` that the decoder consumes.

## Interface
- `K`, 8, number of t1 polynomials (rows of the public matrix).
- `T1_POLY_BYTES`, 320, packed bytes per t1 polynomial (256 coefficients × 10 bits).
- `PK_BYTES`, 32 + K·T1_POLY_BYTES (2592), total key length in bytes; derived, not overridden.
- `CNT_W`, $clog2(PK_BYTES), width of the byte counter; derived.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin loading a new key.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  key byte, in key order (byte 0 first).
- `in_ready`  out  1  loader accepts a byte this cycle.
- `pk_out`  out  8·PK_BYTES  assembled key; byte i at bits [8i+7:8i].
- `out_valid`  out  1  `pk_out` holds a complete key; held until acknowledged.
- `out_ack`  in  1  consumer has taken `pk_out`.
- `busy`  out  1  high in LOAD or DONE.
- `byte_cnt`  out  CNT_W  number of bytes accepted in the current load.
- `err`  out  1  sticky protocol error (only with PK_LOADER_ERR_EN; tied 0 otherwise).

## Operation
- States: IDLE, LOAD, DONE.
- Reset: state IDLE, `byte_cnt` 0, `pk_out` all zeros, `out_valid` 0, `in_ready` 0, `busy` 0, `err` 0.
- IDLE: `in_ready` 0. On `start`, go to LOAD and clear `byte_cnt` to 0. `pk_out` is not cleared; every byte is overwritten during the load.
- LOAD: `in_ready` 1. A handshake (`in_valid & in_ready`) writes `in_data` to byte slot `byte_cnt` and increments `byte_cnt`.
- LOAD completion: the handshake with `byte_cnt == PK_BYTES-1` moves to DONE. `byte_cnt` becomes PK_BYTES.
- LOAD restart: `start` in LOAD resets `byte_cnt` to 0 and stays in LOAD. A byte presented in that same cycle is dropped, so restart wins.
- DONE: `out_valid` 1, `in_ready` 0. `pk_out` and `byte_cnt` are frozen.
  - `out_ack` alone: go to IDLE.
  - `out_ack` together with `start`: go to LOAD with `byte_cnt` 0.
  - `start` without `out_ack`: ignored.
- `in_valid` while `in_ready` is 0: the byte is dropped and state is unchanged.
- Asynchronous reset mid-load or in DONE: immediate return to reset values. The partial key is discarded.

## Timing
- `in_ready`, `out_valid` and `busy` decode combinationally from the state register. No combinational path runs from `in_valid` or `out_ack` to any output.
- Throughput: one byte per cycle. In LOAD, `in_ready` never deasserts until the last byte.
- Latency, with `start` at cycle 0 and `in_valid` held high:
  - LOAD from cycle 1;
  - bytes accepted on cycles 1..PK_BYTES;
  - `out_valid` high from cycle PK_BYTES+1.
- `pk_out` byte i is stable from the cycle after its handshake.
- The decoder may sample `pk_out` on any cycle in which `out_valid` is 1.
- `out_valid` falls the cycle after `out_ack`.

## Configuration
- `PK_LOADER_ERR_EN` defined: `err` is set, and stays set until reset, on either condition:
  - `in_valid` is high while in IDLE or DONE;
  - `start` is high in DONE without `out_ack`.
  
  Datapath behaviour is unchanged.
- Not defined: the `err` logic is absent and the port is tied to 0.

## Test plan
- Nominal load, K=8: `start`, then bytes 0..2591 with value `i mod 256` back-to-back. Required:
  - `out_valid` rises at cycle 2593;
  - `pk_out[7:0]` = 0x00, `pk_out[255:248]` = 0x1F, `pk_out[20735:20728]` = 0x1F;
  - `byte_cnt` = 2592.
- Stalled stream, K=2 (PK_BYTES 672): drive `in_valid` on alternate cycles. Required: `out_valid` only after the 672nd handshake, and all bytes land in the correct slots.
- Restart mid-load: `start` after 100 bytes with `in_valid` high in the same cycle, then 2592 fresh bytes of 0xA5. Required: every `pk_out` byte = 0xA5 and `out_valid` at the expected cycle.
- DONE hold: withhold `out_ack` for 50 cycles while toggling `start` and `in_valid`. Required:
  - `pk_out` unchanged and `in_ready` 0;
  - with the macro defined, `err` = 1.
  
  Then `out_ack` together with `start`: next cycle in LOAD with `byte_cnt` 0.
- Reset mid-load: assert `rst_n` low after 1000 bytes. Required: outputs return to reset values immediately, and a subsequent full load completes correctly.
- Idle bytes: `in_valid` with 0x55 while in IDLE. Required: `pk_out` unchanged, `byte_cnt` 0, and `err` 1 only when the macro is defined.
